// File: rtl/count2421_seq.sv
// count2421_seq: cascaded 2421 (Aiken) BCD counter with run/pause/done control and snapshot handshake.
// Optional up/down counting is enabled by defining COUNT2421_DOWN_EN (adds the 'down' input).
module count2421_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_clear,
    input  logic                tick,
`ifdef COUNT2421_DOWN_EN
    input  logic                down,
`endif
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                wrap,
    output logic                err,
    output logic                snap_valid,
    input  logic                snap_ready,
    output logic [4*DIGITS-1:0] snap,
    output logic                snap_ovf
);
    localparam int W = 4 * DIGITS;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t         state, state_n;
    logic [W-1:0]   count_n, cnt_adv;
    logic           done_n, wrap_n, err_n, roll, lim_ok, capture, dn, c;
    logic [3:0]     d;

`ifdef COUNT2421_DOWN_EN
    assign dn = down;
`else
    assign dn = 1'b0;
`endif

    function automatic logic [3:0] dec(input logic [3:0] code);
        return code[3] ? code - 4'd6 : code;
    endfunction

    function automatic logic [3:0] enc(input logic [3:0] val);
        return (val >= 4'd5) ? val + 4'd6 : val;
    endfunction

    // ripple the +1/-1 through the digits; roll marks a full wrap of the whole counter
    always_comb begin
        cnt_adv = count;
        c = 1'b1;
        d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (c)
                cnt_adv[4*i +: 4] = dn ? ((d == 4'h0) ? 4'hF : enc(dec(d) - 4'd1))
                                       : ((d == 4'hF) ? 4'h0 : enc(dec(d) + 4'd1));
            c = c & (d == (dn ? 4'h0 : 4'hF));
        end
        roll = c;
    end

    // a limit is usable only if no digit falls in the unused 0101..1010 gap
    always_comb begin
        lim_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            lim_ok = lim_ok & ~((limit[4*i +: 4] >= 4'd5) && (limit[4*i +: 4] <= 4'd10));
    end

    // next state and count, honouring clear > start > stop > tick
    always_comb begin
        state_n = state;
        count_n = count;
        done_n  = 1'b0;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (cmd_clear) begin
            state_n = IDLE;
            count_n = '0;
        end else if (cmd_start && state != RUN) begin
            if (!lim_ok)
                err_n = 1'b1;
            else begin
                state_n = RUN;
                count_n = (state == PAUSE) ? count : '0;
            end
        end else if (state == RUN && cmd_stop) begin
            state_n = PAUSE;
        end else if (state == RUN && tick) begin
            count_n = cnt_adv;
            wrap_n  = roll;
            if (limit != '0 && cnt_adv == limit) begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end
    end

    assign capture = (state == RUN) && (state_n == PAUSE || state_n == DONE);

    // state, count and one-cycle status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            done  <= done_n;
            wrap  <= wrap_n;
            err   <= err_n;
        end
    end

    // snapshot register: an unconsumed snapshot is never overwritten, overflow is sticky
    always_ff @(posedge clock) begin
        if (reset || cmd_clear) begin
            snap       <= '0;
            snap_valid <= 1'b0;
            snap_ovf   <= 1'b0;
        end else if (capture) begin
            if (snap_valid && !snap_ready)
                snap_ovf <= 1'b1;
            else begin
                snap       <= count_n;
                snap_valid <= 1'b1;
            end
        end else if (snap_ready) begin
            snap_valid <= 1'b0;
        end
    end

    // busy reflects the RUN state only
    always_comb busy = (state == RUN);
endmodule

// File: tb/tb_count2421_seq.sv
// tb_count2421_seq: directed scoreboard bench for count2421_seq with DIGITS=2.
module tb_count2421_seq;
    logic       clock = 1'b0;
    logic       reset = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_clear = 1'b0, tick = 1'b0;
    logic       snap_ready = 1'b0, rdy = 1'b0;
    logic [7:0] limit = '0, count, snap;
    logic       busy, done, wrap, err, snap_valid, snap_ovf;
    int         checks = 0, failures = 0;

    typedef struct packed {
        logic [7:0] count;
        logic       busy, done, wrap, err, sv, ovf;
        logic [7:0] snap;
    } obs_t;
    obs_t q[$];

    logic [3:0] aik [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    int m_st = 0, m_cnt = 0, m_snap = 0;
    bit m_sv = 0, m_ovf = 0, m_done = 0, m_wrap = 0, m_err = 0;

    count2421_seq #(.DIGITS(2)) dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_clear(cmd_clear), .tick(tick),
`ifdef COUNT2421_DOWN_EN
        .down(1'b0),
`endif
        .limit(limit), .count(count), .busy(busy), .done(done), .wrap(wrap), .err(err),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .snap(snap), .snap_ovf(snap_ovf)
    );

    always #5 clock = ~clock;

    function automatic int a2d(input logic [3:0] code);
        for (int k = 0; k < 10; k++) if (aik[k] == code) return k;
        return -1;
    endfunction

    function automatic logic [7:0] d2a(input int n);
        return {aik[n / 10], aik[n % 10]};
    endfunction

    task automatic model(input logic st, sp, cl, tk, rs);
        bit cap = 0;
        int lo = a2d(limit[3:0]);
        int hi = a2d(limit[7:4]);
        bit ok = (lo >= 0) && (hi >= 0);
        int ld = hi * 10 + lo;
        m_done = 0; m_wrap = 0; m_err = 0;
        if (rs || cl) begin
            m_st = 0; m_cnt = 0; m_snap = 0; m_sv = 0; m_ovf = 0;
        end else begin
            if (st && m_st != 1) begin
                if (!ok) m_err = 1;
                else begin
                    if (m_st != 2) m_cnt = 0;
                    m_st = 1;
                end
            end else if (m_st == 1 && sp) begin
                m_st = 2; cap = 1;
            end else if (m_st == 1 && tk) begin
                m_cnt = (m_cnt + 1) % 100;
                m_wrap = (m_cnt == 0);
                if (ok && ld != 0 && m_cnt == ld) begin
                    m_st = 3; m_done = 1; cap = 1;
                end
            end
            if (cap) begin
                if (m_sv && !rdy) m_ovf = 1;
                else begin m_snap = m_cnt; m_sv = 1; end
            end else if (rdy) m_sv = 0;
        end
    endtask

    task automatic cyc(input logic st, sp, cl, tk, rs);
        obs_t o, e;
        reset = rs; cmd_start = st; cmd_stop = sp; cmd_clear = cl; tick = tk; snap_ready = rdy;
        model(st, sp, cl, tk, rs);
        q.push_back({d2a(m_cnt), m_st == 1, m_done, m_wrap, m_err, m_sv, m_ovf, d2a(m_snap)});
        @(posedge clock);
        #1;
        o = {count, busy, done, wrap, err, snap_valid, snap_ovf, snap};
        e = q.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL cycle obs=%h exp=%h", o, e);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_count", count, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        limit = 8'h1B;
        cyc(1, 0, 0, 0, 0);
        chk("start_busy", {7'd0, busy}, 8'h01);
        repeat (15) cyc(0, 0, 0, 1, 0);
        chk("lim_count", count, 8'h1B);
        chk("lim_done", {7'd0, done}, 8'h01);
        chk("lim_busy", {7'd0, busy}, 8'h00);
        chk("lim_snap", snap, 8'h1B);
        chk("lim_sv", {7'd0, snap_valid}, 8'h01);
        cyc(0, 0, 0, 0, 0);
        chk("done_pulse", {7'd0, done}, 8'h00);
        limit = 8'h00;
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        chk("cnt_04", count, 8'h04);
        cyc(0, 0, 0, 1, 0);
        chk("cnt_05", count, 8'h0B);
        repeat (4) cyc(0, 0, 0, 1, 0);
        chk("cnt_09", count, 8'h0F);
        cyc(0, 0, 0, 1, 0);
        chk("cnt_10", count, 8'h10);
        repeat (89) cyc(0, 0, 0, 1, 0);
        chk("cnt_99", count, 8'hFF);
        cyc(0, 0, 0, 1, 0);
        chk("wrap_count", count, 8'h00);
        chk("wrap_pulse", {7'd0, wrap}, 8'h01);
        chk("wrap_busy", {7'd0, busy}, 8'h01);
        cyc(0, 0, 0, 1, 0);
        chk("wrap_end", {7'd0, wrap}, 8'h00);
        repeat (2) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        limit = 8'h60;
        cyc(1, 0, 0, 0, 0);
        chk("err_pulse", {7'd0, err}, 8'h01);
        chk("err_busy", {7'd0, busy}, 8'h00);
        chk("err_count", count, 8'h03);
        cyc(0, 0, 0, 0, 0);
        chk("err_end", {7'd0, err}, 8'h00);
        limit = 8'h00;
        cyc(1, 0, 0, 0, 0);
        chk("resume_busy", {7'd0, busy}, 8'h01);
        chk("resume_count", count, 8'h03);
        rdy = 1;
        cyc(0, 0, 0, 1, 0);
        chk("ready_drain", {7'd0, snap_valid}, 8'h00);
        rdy = 0;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("snap1", snap, 8'h0B);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("ovf_snap", snap, 8'h0B);
        chk("ovf_flag", {7'd0, snap_ovf}, 8'h01);
        chk("ovf_count", count, 8'h0C);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        rdy = 1;
        cyc(0, 1, 0, 0, 0);
        chk("reload_snap", snap, 8'h0D);
        chk("reload_sv", {7'd0, snap_valid}, 8'h01);
        rdy = 0;
        cyc(0, 0, 1, 0, 0);
        chk("clr_count", count, 8'h00);
        chk("clr_snap", snap, 8'h00);
        chk("clr_flags", {4'd0, busy, snap_valid, snap_ovf, err}, 8'h00);
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 1);
        chk("rst_run_count", count, 8'h00);
        chk("rst_run_snap", snap, 8'h00);
        chk("rst_run_flags", {1'b0, busy, done, wrap, err, snap_valid, snap_ovf, 1'b0}, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
